// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: oversampling UART receiver with a show-ahead word FIFO.
//
// The line is resynchronised, start/stop bits are validated at mid-bit, and
// each good word is pushed into a DEPTH-entry FIFO that the consumer drains
// at its own pace.
//
// Optional feature macro: UART_RX_PARITY_EN. When it is defined, a parity bit
// follows the data bits and the i_parity_odd input is present. When it is not
// defined, there is no parity bit and o_parity_err is always 0.
//
// Ports:
//   i_clk         system clock
//   i_reset       synchronous, active-high reset
//   i_baud_tick   one-clk enable, OVERSAMPLE pulses per bit period
//   i_rx_in       asynchronous serial line, idle high
//   i_parity_odd  1 = odd parity, 0 = even (UART_RX_PARITY_EN only)
//   i_rd_en       pop the head word; ignored while the FIFO is empty
//   o_rx_data     FIFO head word, 0 while the FIFO is empty
//   o_rx_valid    FIFO not empty
//   o_rx_count    FIFO occupancy, 0..DEPTH
//   o_frame_err   1-clk pulse: a stop bit was sampled low
//   o_overflow    1-clk pulse: a completed word was dropped (FIFO full)
//   o_parity_err  1-clk pulse: parity mismatch
module uart_rx_fifo #(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_baud_tick,
  input  logic                   i_rx_in,
`ifdef UART_RX_PARITY_EN
  input  logic                   i_parity_odd,
`endif
  input  logic                   i_rd_en,
  output logic [DATA_BITS-1:0]   o_rx_data,
  output logic                   o_rx_valid,
  output logic [$clog2(DEPTH):0] o_rx_count,
  output logic                   o_frame_err,
  output logic                   o_overflow,
  output logic                   o_parity_err
);

  localparam int unsigned TW = $clog2(OVERSAMPLE);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);
  localparam logic [AW:0]   FULL      = (AW + 1)'(DEPTH);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
`ifdef UART_RX_PARITY_EN
    StParity,
`endif
    StStop,
    StBreak
  } state_t;

  // Receiver registers
  logic [1:0]           r_sync;
  logic                 r_prev;      // line level at the previous baud tick
  state_t               r_state;
  logic [TW-1:0]        r_tick;
  logic [3:0]           r_bit;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_stop_bad;
  logic                 r_par_bad;
  logic                 r_commit;
  logic                 r_frame_err;
  logic                 r_parity_err;
`ifdef UART_RX_PARITY_EN
  logic                 r_par_odd;
`endif

  // FIFO registers
  logic [DATA_BITS-1:0] r_mem [DEPTH];
  logic [AW-1:0]        r_wr_ptr;
  logic [AW-1:0]        r_rd_ptr;
  logic [AW:0]          r_count;
  logic                 r_overflow;

  // Next-state wires
  logic                 w_rx;
  logic                 w_mid;
  logic [TW-1:0]        w_tick_inc;
  state_t               w_state_nxt;
  logic [TW-1:0]        w_tick_nxt;
  logic [3:0]           w_bit_nxt;
  logic [DATA_BITS-1:0] w_shift_nxt;
  logic                 w_prev_nxt;
  logic                 w_stop_bad_nxt;
  logic                 w_par_bad_nxt;
  logic                 w_commit_nxt;
  logic                 w_frame_err_nxt;
  logic                 w_parity_err_nxt;
  logic                 w_full;
  logic                 w_pop;
  logic                 w_push;

  assign w_rx       = r_sync[1];
  assign w_mid      = (r_tick == TICK_MID);
  // The tick counter free-runs from the start edge, so every later mid-bit
  // point lands exactly one bit period after the previous one.
  assign w_tick_inc = (r_tick == TICK_LAST) ? '0 : r_tick + 1'b1;

  always_comb begin
    w_state_nxt      = r_state;
    w_tick_nxt       = r_tick;
    w_bit_nxt        = r_bit;
    w_shift_nxt      = r_shift;
    w_prev_nxt       = r_prev;
    w_stop_bad_nxt   = r_stop_bad;
    w_par_bad_nxt    = r_par_bad;
    w_commit_nxt     = 1'b0;
    w_frame_err_nxt  = 1'b0;
    w_parity_err_nxt = 1'b0;
    if (i_baud_tick) begin
      w_prev_nxt = w_rx;
      w_tick_nxt = w_tick_inc;
      unique case (r_state)
        StIdle: begin
          if (r_prev && !w_rx) begin
            w_state_nxt    = StStart;
            w_tick_nxt     = '0;
            w_bit_nxt      = '0;
            w_stop_bad_nxt = 1'b0;
            w_par_bad_nxt  = 1'b0;
          end
        end
        StStart: begin
          if (w_mid) w_state_nxt = w_rx ? StIdle : StData;
        end
        StData: begin
          if (w_mid) begin
            w_shift_nxt = {w_rx, r_shift[DATA_BITS-1:1]};
            if (r_bit == DATA_LAST) begin
              w_bit_nxt   = '0;
`ifdef UART_RX_PARITY_EN
              w_state_nxt = StParity;
`else
              w_state_nxt = StStop;
`endif
            end else begin
              w_bit_nxt = r_bit + 4'd1;
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        StParity: begin
          if (w_mid) begin
            w_par_bad_nxt = w_rx != ((^r_shift) ^ r_par_odd);
            w_state_nxt   = StStop;
          end
        end
`endif
        StStop: begin
          if (w_mid) begin
            if (r_bit == STOP_LAST) begin
              w_bit_nxt = '0;
              // Frame error outranks parity error; either one drops the word.
              if (r_stop_bad || !w_rx) begin
                w_frame_err_nxt = 1'b1;
                w_state_nxt     = StBreak;
              end else if (r_par_bad) begin
                w_parity_err_nxt = 1'b1;
                w_state_nxt      = StIdle;
              end else begin
                w_commit_nxt = 1'b1;
                w_state_nxt  = StIdle;
              end
            end else begin
              w_stop_bad_nxt = r_stop_bad | !w_rx;
              w_bit_nxt      = r_bit + 4'd1;
            end
          end
        end
        StBreak: begin
          if (w_rx) w_state_nxt = StIdle;
        end
        default: w_state_nxt = StIdle;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_sync       <= 2'b11;
      r_prev       <= 1'b1;
      r_state      <= StIdle;
      r_tick       <= '0;
      r_bit        <= '0;
      r_shift      <= '0;
      r_stop_bad   <= 1'b0;
      r_par_bad    <= 1'b0;
      r_commit     <= 1'b0;
      r_frame_err  <= 1'b0;
      r_parity_err <= 1'b0;
    end else begin
      r_sync       <= {r_sync[0], i_rx_in};
      r_prev       <= w_prev_nxt;
      r_state      <= w_state_nxt;
      r_tick       <= w_tick_nxt;
      r_bit        <= w_bit_nxt;
      r_shift      <= w_shift_nxt;
      r_stop_bad   <= w_stop_bad_nxt;
      r_par_bad    <= w_par_bad_nxt;
      r_commit     <= w_commit_nxt;
      r_frame_err  <= w_frame_err_nxt;
      r_parity_err <= w_parity_err_nxt;
    end
  end

`ifdef UART_RX_PARITY_EN
  // Parity sense is latched at the start edge so it is stable for the frame.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_par_odd <= 1'b0;
    end else if (i_baud_tick && r_state == StIdle && r_prev && !w_rx) begin
      r_par_odd <= i_parity_odd;
    end
  end
`endif

  // FIFO. r_shift is untouched until the next frame's data bits, so it still
  // holds the committed word on the cycle after r_commit.
  assign w_full = (r_count == FULL);
  assign w_pop  = i_rd_en && (r_count != '0);
  assign w_push = r_commit && (!w_full || w_pop);

  always_ff @(posedge i_clk) begin
    if (!i_reset && w_push) r_mem[r_wr_ptr] <= r_shift;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (!w_push && w_pop) r_count <= r_count - 1'b1;
      r_overflow <= r_commit && w_full && !w_pop;
    end
  end

  assign o_rx_valid   = (r_count != '0);
  assign o_rx_count   = r_count;
  assign o_rx_data    = o_rx_valid ? r_mem[r_rd_ptr] : '0;
  assign o_frame_err  = r_frame_err;
  assign o_overflow   = r_overflow;
  assign o_parity_err = r_parity_err;

endmodule
